// File: rtl/rename_pkg.sv
// Shared renamer types: physical tag, writeback bus layout, reorder-queue index.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rename_pkg;

  localparam int PTAG_W    = 4;
  localparam int NUM_PHYS  = 16;
  localparam int NUM_ARCH  = 8;
  localparam int ROB_DEPTH = 8;

  typedef logic [PTAG_W-1:0] ptag_t;

  // Renamer writeback bus: the tag displaced by the write, then the tag it claimed.
  typedef struct packed {
    ptag_t old_tag;
    ptag_t new_tag;
  } wbs_t;

  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;

endpackage

// File: rtl/retire_sched.sv
// In-order retire scheduler: circular reorder queue of displaced tags, drained in program order.
// Latency: done at edge N -> retire_ena high after edge N+1 -> free_cnt restored at edge N+2.
// Backpressure: alloc_ready drops when the queue is full or no physical tag is free.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   alloc_valid/ready     rename write handshake; rename_ena = accepted this cycle
//   alloc_wbs             {old_tag, new_tag}; only old_tag is kept in the slot
//   alloc_idx             slot the current request would occupy (tail)
//   done_valid/done_idx   completion report for a slot
//   retire_ena/retire_tag one-cycle pulse releasing a displaced tag
//   occupancy, free_cnt   live slots, free physical tags
module retire_sched
  import rename_pkg::*;
#(
  parameter int DEPTH    = rename_pkg::ROB_DEPTH,
  parameter int PTAG_W   = rename_pkg::PTAG_W,
  parameter int NUM_PHYS = rename_pkg::NUM_PHYS,
  parameter int NUM_ARCH = rename_pkg::NUM_ARCH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [2*PTAG_W-1:0]           alloc_wbs,
  output logic                          rename_ena,
  output logic [$clog2(DEPTH)-1:0]      alloc_idx,
  input  logic                          done_valid,
  input  logic [$clog2(DEPTH)-1:0]      done_idx,
  output logic                          retire_ena,
  output logic [PTAG_W-1:0]             retire_tag,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic [$clog2(NUM_PHYS):0]     free_cnt
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(NUM_PHYS) + 1;
  localparam int FREE_MAX = NUM_PHYS - NUM_ARCH;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       head, tail;
  logic [AW-1:0]     head_idx, tail_idx;
  logic [DEPTH-1:0]  slot_vld, slot_done;
  logic [PTAG_W-1:0] slot_tag [DEPTH];

  logic full, accept, commit;

  // The new tag is owned by the renamer; this block only needs what it displaced.
  logic unused_new_tag;
  assign unused_new_tag = ^alloc_wbs[PTAG_W-1:0];

  assign head_idx    = head[AW-1:0];
  assign tail_idx    = tail[AW-1:0];
  assign full        = (head_idx == tail_idx) && (head[AW] != tail[AW]);
  assign alloc_ready = !full && (free_cnt != '0);
  assign accept      = alloc_valid && alloc_ready;
  assign rename_ena  = accept;
  assign alloc_idx   = tail_idx;
  assign occupancy   = tail - head;
  // Uses the pre-edge done bit, so a done for the head commits one edge later.
  assign commit      = slot_vld[head_idx] && slot_done[head_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      slot_vld   <= '0;
      slot_done  <= '0;
      for (int i = 0; i < DEPTH; i++) slot_tag[i] <= '0;
      retire_ena <= 1'b0;
      retire_tag <= '0;
      free_cnt   <= CW'(FREE_MAX);
    end else begin
      // A report for an invalid slot (including one being allocated this edge) is dropped.
      if (done_valid && slot_vld[done_idx]) slot_done[done_idx] <= 1'b1;

      // Accept and commit never target the same slot: equal indices mean empty
      // (nothing to commit) or full (alloc refused).
      if (accept) begin
        slot_vld[tail_idx]  <= 1'b1;
        slot_done[tail_idx] <= 1'b0;
        slot_tag[tail_idx]  <= alloc_wbs[2*PTAG_W-1:PTAG_W];
        tail                <= tail + 1'b1;
      end

      if (commit) begin
        slot_vld[head_idx]  <= 1'b0;
        slot_done[head_idx] <= 1'b0;
        head                <= head + 1'b1;
        retire_tag          <= slot_tag[head_idx];
      end
      retire_ena <= commit;

      // The tag is returned on the edge after the pulse, when the renamer unclaims it.
      case ({accept, retire_ena})
        2'b10:   free_cnt <= free_cnt - 1'b1;
        2'b01:   if (free_cnt != CW'(FREE_MAX)) free_cnt <= free_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Returning a tag when all non-architectural tags are already free is a design error.
  a_free_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (retire_ena && !accept) |-> (free_cnt != CW'(FREE_MAX)));

endmodule

// File: tb/tb_retire_sched.sv
module tb_retire_sched;
  import rename_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [7:0] alloc_wbs;
  logic       rename_ena;
  logic [2:0] alloc_idx;
  logic       done_valid;
  logic [2:0] done_idx;
  logic       retire_ena;
  logic [3:0] retire_tag;
  logic [3:0] occupancy;
  logic [4:0] free_cnt;

  int    total = 0;
  int    bad = 0;
  int    ret_cnt = 0;
  ptag_t exp_q[$];
  ptag_t exp_tag;
  logic [2:0] m_tail;

  retire_sched dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_wbs(alloc_wbs),
    .rename_ena(rename_ena), .alloc_idx(alloc_idx),
    .done_valid(done_valid), .done_idx(done_idx),
    .retire_ena(retire_ena), .retire_tag(retire_tag),
    .occupancy(occupancy), .free_cnt(free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and scoreboard any retire pulse against program order.
  task automatic tick();
    @(posedge clk);
    #1;
    if (retire_ena) begin
      ret_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL retire_order: got unexpected retire tag %0d, want none", retire_tag);
      end else begin
        exp_tag = exp_q.pop_front();
        if (retire_tag !== exp_tag) begin
          bad++;
          $display("FAIL retire_order: got tag %0d want %0d", retire_tag, exp_tag);
        end
      end
    end
  endtask

  task automatic apply_reset();
    alloc_valid = 1'b0;
    alloc_wbs   = '0;
    done_valid  = 1'b0;
    done_idx    = '0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_tail = '0;
    exp_q.delete();
  endtask

  // Drive an alloc the caller expects to be accepted; the caller ticks.
  task automatic push_alloc(input ptag_t old_t, input ptag_t new_t);
    wbs_t w;
    w.old_tag   = old_t;
    w.new_tag   = new_t;
    alloc_valid = 1'b1;
    alloc_wbs   = w;
    exp_q.push_back(old_t);
    m_tail = m_tail + 3'd1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", alloc_ready); end
    total++; if (free_cnt !== 5'd8) begin bad++; $display("FAIL rst_free: got %0d want 8", free_cnt); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    total++; if (retire_ena !== 1'b0) begin bad++; $display("FAIL rst_retire: got %0b want 0", retire_ena); end
    total++; if (alloc_idx !== 3'd0) begin bad++; $display("FAIL rst_idx: got %0d want 0", alloc_idx); end
    total++; if (retire_tag !== 4'd0) begin bad++; $display("FAIL rst_tag: got %0d want 0", retire_tag); end
    alloc_valid = 1'b1;
    #1;
    total++; if (rename_ena !== 1'b1) begin bad++; $display("FAIL rename_ena: got %0b want 1", rename_ena); end
    alloc_valid = 1'b0;
    #1;
    total++; if (rename_ena !== 1'b0) begin bad++; $display("FAIL rename_idle: got %0b want 0", rename_ena); end
  endtask

  task automatic test_single();
    apply_reset();
    push_alloc(4'd3, 4'd9);
    tick();
    alloc_valid = 1'b0;
    total++; if (free_cnt !== 5'd7) begin bad++; $display("FAIL single_free_dec: got %0d want 7", free_cnt); end
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    done_valid = 1'b1; done_idx = 3'd0;
    tick();
    done_valid = 1'b0;
    total++; if (retire_ena !== 1'b0) begin bad++; $display("FAIL single_early: got %0b want 0", retire_ena); end
    tick();
    total++; if (retire_ena !== 1'b1 || retire_tag !== 4'd3) begin bad++; $display("FAIL single_pulse: got ena=%0b tag=%0d want ena=1 tag=3", retire_ena, retire_tag); end
    total++; if (free_cnt !== 5'd7) begin bad++; $display("FAIL single_free_hold: got %0d want 7", free_cnt); end
    tick();
    total++; if (retire_ena !== 1'b0) begin bad++; $display("FAIL single_one_pulse: got %0b want 0", retire_ena); end
    total++; if (free_cnt !== 5'd8) begin bad++; $display("FAIL single_free_inc: got %0d want 8", free_cnt); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      push_alloc(ptag_t'(i + 1), ptag_t'(i + 8));
      tick();
    end
    alloc_valid = 1'b0;
    total++; if (free_cnt !== 5'd0) begin bad++; $display("FAIL full_free: got %0d want 0", free_cnt); end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", alloc_ready); end
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_occ: got %0d want 8", occupancy); end
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_refuse: got occ %0d want 8", occupancy); end
    done_valid = 1'b1; done_idx = 3'd0;
    tick();
    done_valid = 1'b0;
    tick();
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready_pulse: got %0b want 0", alloc_ready); end
    tick();
    total++; if (free_cnt !== 5'd1 || alloc_ready !== 1'b1) begin bad++; $display("FAIL full_reopen: got free=%0d ready=%0b want free=1 ready=1", free_cnt, alloc_ready); end
    for (int i = 1; i < 8; i++) begin
      done_valid = 1'b1; done_idx = 3'(i);
      tick();
    end
    done_valid = 1'b0;
    repeat (3) tick();
    total++; if (free_cnt !== 5'd8 || occupancy !== 4'd0) begin bad++; $display("FAIL full_drain: got free=%0d occ=%0d want free=8 occ=0", free_cnt, occupancy); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_missing: got %0d retires outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_ooo();
    apply_reset();
    push_alloc(4'd1, 4'd0); tick();
    push_alloc(4'd2, 4'd0); tick();
    push_alloc(4'd4, 4'd0); tick();
    alloc_valid = 1'b0;
    done_valid = 1'b1;
    done_idx = 3'd2; tick();
    done_idx = 3'd1; tick();
    done_idx = 3'd0; tick();
    done_valid = 1'b0;
    total++; if (retire_ena !== 1'b0) begin bad++; $display("FAIL ooo_early: got %0b want 0", retire_ena); end
    tick();
    total++; if (retire_ena !== 1'b1 || retire_tag !== 4'd1) begin bad++; $display("FAIL ooo_first: got ena=%0b tag=%0d want ena=1 tag=1", retire_ena, retire_tag); end
    tick();
    total++; if (retire_ena !== 1'b1 || retire_tag !== 4'd2) begin bad++; $display("FAIL ooo_second: got ena=%0b tag=%0d want ena=1 tag=2", retire_ena, retire_tag); end
    tick();
    total++; if (retire_ena !== 1'b1 || retire_tag !== 4'd4) begin bad++; $display("FAIL ooo_third: got ena=%0b tag=%0d want ena=1 tag=4", retire_ena, retire_tag); end
    tick();
    total++; if (retire_ena !== 1'b0) begin bad++; $display("FAIL ooo_end: got %0b want 0", retire_ena); end
  endtask

  task automatic test_same_edge();
    int r0;
    apply_reset();
    r0 = ret_cnt;
    push_alloc(4'd5, 4'd6);
    done_valid = 1'b1; done_idx = 3'd0;
    tick();
    alloc_valid = 1'b0; done_valid = 1'b0;
    repeat (3) tick();
    total++; if (ret_cnt != r0) begin bad++; $display("FAIL same_edge_drop: got %0d retires want 0", ret_cnt - r0); end
    total++; if (occupancy !== 4'd1 || free_cnt !== 5'd7) begin bad++; $display("FAIL same_edge_state: got occ=%0d free=%0d want occ=1 free=7", occupancy, free_cnt); end
    done_valid = 1'b1; done_idx = 3'd0;
    tick();
    done_valid = 1'b0;
    repeat (3) tick();
    total++; if (ret_cnt != r0 + 1) begin bad++; $display("FAIL same_edge_later: got %0d retires want 1", ret_cnt - r0); end
    total++; if (free_cnt !== 5'd8 || occupancy !== 4'd0) begin bad++; $display("FAIL same_edge_free: got free=%0d occ=%0d want free=8 occ=0", free_cnt, occupancy); end
  endtask

  task automatic test_wrap_and_reset();
    logic [3:0] e_occ;
    logic [4:0] e_free;
    int r0;
    apply_reset();
    // Alloc every cycle, complete the previous cycle's slot: steady occupancy 2, free 5.
    for (int i = 0; i < 20; i++) begin
      push_alloc(ptag_t'(i), 4'd0);
      if (i > 0) begin done_valid = 1'b1; done_idx = 3'(i - 1); end
      else done_valid = 1'b0;
      tick();
      e_occ  = (i == 0) ? 4'd1 : 4'd2;
      e_free = (i == 0) ? 5'd7 : (i == 1) ? 5'd6 : 5'd5;
      total++; if (occupancy !== e_occ || free_cnt !== e_free || alloc_idx !== m_tail) begin
        bad++; $display("FAIL wrap_step%0d: got occ=%0d free=%0d idx=%0d want occ=%0d free=%0d idx=%0d",
                        i, occupancy, free_cnt, alloc_idx, e_occ, e_free, m_tail);
      end
    end
    alloc_valid = 1'b0;
    done_valid = 1'b1; done_idx = 3'd3;
    tick();
    done_valid = 1'b0;
    repeat (3) tick();
    total++; if (occupancy !== 4'd0 || free_cnt !== 5'd8 || exp_q.size() != 0) begin
      bad++; $display("FAIL wrap_drain: got occ=%0d free=%0d pending=%0d want 0 8 0", occupancy, free_cnt, exp_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      push_alloc(ptag_t'(15 - i), 4'd0);
      tick();
    end
    alloc_valid = 1'b0;
    total++; if (alloc_ready !== 1'b0 || occupancy !== 4'd8 || alloc_idx !== m_tail) begin
      bad++; $display("FAIL wrap_full: got ready=%0b occ=%0d idx=%0d want 0 8 %0d", alloc_ready, occupancy, alloc_idx, m_tail);
    end
    // Asynchronous reset in the middle of a cycle discards every in-flight slot.
    r0 = ret_cnt;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (alloc_ready !== 1'b1 || free_cnt !== 5'd8 || occupancy !== 4'd0 || retire_ena !== 1'b0 || alloc_idx !== 3'd0) begin
      bad++; $display("FAIL async_reset: got ready=%0b free=%0d occ=%0d ena=%0b idx=%0d want 1 8 0 0 0",
                      alloc_ready, free_cnt, occupancy, retire_ena, alloc_idx);
    end
    exp_q.delete();
    m_tail = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    total++; if (ret_cnt != r0 || occupancy !== 4'd0) begin bad++; $display("FAIL reset_discard: got retires=%0d occ=%0d want 0 0", ret_cnt - r0, occupancy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_ooo();
    test_same_edge();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retire_sched.md
# retire_sched

In-order retire scheduler for the register renamer. Each rename write accepted by this block gets a slot in an 8-entry circular reorder queue, which holds the previous physical tag the write displaced. Completion reports mark slots done. Completed slots drain in program order, one per cycle, as retire pulses that release the displaced tag back to the renamer. The block also tracks free physical registers and stalls rename when the queue is full or no tag is free.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two.
- PTAG_W, 4: physical tag width.
- NUM_PHYS, 16: physical registers.
- NUM_ARCH, 8: architectural registers; tags in use at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  decode requests a rename write.
- alloc_ready  out  1  slot and free tag available.
- alloc_wbs  in  2*PTAG_W  renamer writeback bus {old_tag, new_tag}.
- rename_ena  out  1  renamer commit enable: alloc_valid & alloc_ready.
- alloc_idx  out  log2(DEPTH)  slot assigned to the current request (tail index).
- done_valid  in  1  completion report.
- done_idx  in  log2(DEPTH)  slot that completed.
- retire_ena  out  1  one-cycle pulse: free retire_tag.
- retire_tag  out  PTAG_W  tag being released.
- occupancy  out  log2(DEPTH)+1  live slots.
- free_cnt  out  log2(NUM_PHYS)+1  free physical tags.

## Operation
- State per slot: valid, done, old_tag.
- Head and tail pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- alloc_ready = !full && free_cnt != 0. It depends only on registered state, never on alloc_valid.
- Accept (alloc_valid & alloc_ready at the edge):
  - write slot[tail] = {valid=1, done=0, old_tag=alloc_wbs[2*PTAG_W-1:PTAG_W]};
  - tail++;
  - free_cnt--.
  - new_tag is not stored.
- Done (done_valid at the edge):
  - if slot[done_idx].valid, set its done bit;
  - otherwise ignore the report (no error);
  - a repeated done on an already-done slot is harmless.
- Commit: if slot[head] is valid && done at the edge:
  - clear the slot, head++;
  - register retire_ena=1 and retire_tag=old_tag.
  - Otherwise retire_ena=0. retire_tag holds its last value and is don't-care when retire_ena=0.
- Free count:
  - free_cnt++ on every edge where the registered retire_ena=1, i.e. the edge on which the renamer unclaims the tag.
  - Alloc and retire on the same edge leave free_cnt unchanged.
  - free_cnt saturates at NUM_PHYS-NUM_ARCH. An attempt to exceed it is a design error, flagged by an assertion.
- At most one alloc, one done and one commit per cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - all slots invalid; head = tail = 0;
  - retire_ena = 0, retire_tag = 0;
  - occupancy = 0; free_cnt = NUM_PHYS-NUM_ARCH (8);
  - therefore alloc_ready = 1 and alloc_idx = 0.
- Reset asserted mid-operation discards all in-flight slots. No retire pulse is produced for discarded slots.
- Latency, for a slot already at the head:
  - done reported at edge N: done bit visible after N;
  - commit at edge N+1: retire_ena high during cycle N+1..N+2;
  - free_cnt updated at edge N+2.
- Done reported on the same edge the slot is allocated: the slot is not yet valid, so the report is dropped.
- Done for the head slot and commit evaluation on the same edge: commit uses the pre-edge done bit, so the commit happens one edge later.
- Full queue with a commit on the same edge: the alloc is still refused that cycle. alloc_ready rises the cycle after the pop.
- free_cnt = 0 with a retire pulse in flight: alloc_ready rises the cycle after the free_cnt increment.
- Pointer wrap: tail index DEPTH-1 → 0 with the wrap bit toggled; full/empty stay correct across any number of wraps.

## Structure
- Shared package rename_pkg holds:
  - PTAG_W, NUM_PHYS, NUM_ARCH, ROB_DEPTH;
  - typedef ptag_t;
  - typedef wbs_t: packed struct {old_tag, new_tag}, matching the renamer writeback bus;
  - typedef rob_idx_t.
- Single module; no sub-module is needed. The queue is flop arrays (valid, done, old_tag) indexed by the pointer low bits.

## Test plan
- Reset, then check outputs → alloc_ready=1, free_cnt=8, occupancy=0, retire_ena=0, alloc_idx=0.
- Alloc wbs {3,9}, done idx 0 next cycle → retire_ena pulses with retire_tag=3 exactly 2 edges after done; free_cnt goes 8→7→8.
- Eight allocs with no done → free_cnt=0 and alloc_ready=0 after the 8th. Then done idx 0 → retire tag pulse, free_cnt=1, alloc_ready=1 one cycle later.
- Out-of-order done: alloc slots 0,1,2 with old tags 1,2,4, then done 2, 1, 0 on successive cycles → retires strictly in order 1,2,4 on consecutive cycles.
- Same edge: alloc and done on the identical empty slot → done dropped, no retire. A later done retires normally.
- 20 alloc/done/retire cycles → occupancy and full/empty correct through the wrap, and free_cnt restores to 8. Also drop rst_n mid-stream → all outputs return to reset values asynchronously.
